// File: rtl/pong_pkg.sv
// Shared Pong definitions: game state encoding, default playfield geometry
// and the serve/reset coordinates derived from it. Imported by the game
// controller and by the renderer top so both agree on sizes and encodings.
package pong_pkg;

    typedef enum logic [1:0] {
        QI      = 2'b00,   // idle, waiting for start
        QGAME_1 = 2'b01,   // serve countdown
        QGAME_2 = 2'b10,   // rally in progress
        QDONE   = 2'b11    // a player has won
    } pong_state_t;

    localparam int unsigned DEF_SCREEN_W     = 640;
    localparam int unsigned DEF_SCREEN_H     = 480;
    localparam int unsigned DEF_PADDLE_H     = 80;
    localparam int unsigned DEF_PADDLE_W     = 10;
    localparam int unsigned DEF_BALL_SZ      = 8;
    localparam int unsigned DEF_P1_X         = 20;
    localparam int unsigned DEF_P2_X         = 610;
    localparam int unsigned DEF_STEP         = 4;
    localparam int unsigned DEF_SPEED        = 2;
    localparam int unsigned DEF_SERVE_FRAMES = 60;
    localparam int unsigned DEF_WIN_SCORE    = 10;

    // Ball serve position (centre of screen) and paddle rest row.
    localparam int unsigned DEF_SERVE_X  = (DEF_SCREEN_W - DEF_BALL_SZ) / 2;   // 316
    localparam int unsigned DEF_SERVE_Y  = (DEF_SCREEN_H - DEF_BALL_SZ) / 2;   // 236
    localparam int unsigned DEF_PADDLE_Y0 = (DEF_SCREEN_H - DEF_PADDLE_H) / 2; // 200

    // Width of the synchronized input bundle {start, p1_up, p1_dn, p2_up, p2_dn}.
    localparam int unsigned SYNC_W = 5;

endpackage

// File: rtl/input_sync.sv
// Parameterized-width two-flop synchronizer for asynchronous level inputs.
// Ports:
//   board_clk  in          destination clock
//   reset      in          asynchronous active-high reset (clears both stages)
//   async_in   in  WIDTH   asynchronous inputs
//   sync_out   out WIDTH   inputs retimed to board_clk, two cycles of latency
module input_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             board_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: paddle motion, ball physics, scoring and the game
// state machine. All motion advances once per frame_tick.
// Ports:
//   board_clk, reset           clock; asynchronous active-high reset
//   frame_tick                 one-cycle pulse per video frame
//   start                      game-enable switch (asynchronous level)
//   p1_up/p1_dn/p2_up/p2_dn    paddle buttons (asynchronous levels)
//   p1_y, p2_y                 paddle top-edge rows
//   ball_x, ball_y             ball top-left pixel
//   p1_score, p2_score         scores, 0..WIN_SCORE
//   state                      00 idle, 01 serve, 10 rally, 11 done
//   game_over                  high while in the done state
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned SCREEN_W     = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H     = DEF_SCREEN_H,
    parameter int unsigned PADDLE_H     = DEF_PADDLE_H,
    parameter int unsigned PADDLE_W     = DEF_PADDLE_W,
    parameter int unsigned BALL_SZ      = DEF_BALL_SZ,
    parameter int unsigned P1_X         = DEF_P1_X,
    parameter int unsigned P2_X         = DEF_P2_X,
    parameter int unsigned STEP         = DEF_STEP,
    parameter int unsigned SPEED        = DEF_SPEED,
    parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    output logic [8:0] p1_y,
    output logic [8:0] p2_y,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] state,
    output logic       game_over
);

    localparam int unsigned CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    // Paddle geometry (9-bit row domain)
    localparam logic [8:0] PAD_Y0   = 9'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [8:0] PAD_MAX  = 9'(SCREEN_H - PADDLE_H);
    localparam logic [8:0] PAD_STEP = 9'(STEP);

    // Horizontal ball math is done one bit wider than ball_x so sums never wrap.
    localparam logic [10:0] X_SERVE  = 11'((SCREEN_W - BALL_SZ) / 2);
    localparam logic [10:0] X_SPD    = 11'(SPEED);
    localparam logic [10:0] X_HIT1   = 11'(P1_X + PADDLE_W);   // P1 paddle face
    localparam logic [10:0] X_HIT2   = 11'(P2_X - BALL_SZ);    // P2 paddle face
    localparam logic [10:0] X_MISS_R = 11'(SCREEN_W - PADDLE_W);

    // Vertical ball math, likewise one bit wider than ball_y.
    localparam logic [9:0] Y_SERVE = 10'((SCREEN_H - BALL_SZ) / 2);
    localparam logic [9:0] Y_SPD   = 10'(SPEED);
    localparam logic [9:0] Y_BOT   = 10'(SCREEN_H - BALL_SZ);
    localparam logic [9:0] Y_BSZ   = 10'(BALL_SZ);
    localparam logic [9:0] Y_PH    = 10'(PADDLE_H);

    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

    // ---------------------------------------------------------------
    // Input synchronization
    // ---------------------------------------------------------------
    logic [SYNC_W-1:0] sync_raw;
    logic [SYNC_W-1:0] sync_q;
    logic start_s, p1_up_s, p1_dn_s, p2_up_s, p2_dn_s;

    assign sync_raw = {start, p1_up, p1_dn, p2_up, p2_dn};

    input_sync #(.WIDTH(SYNC_W)) u_input_sync (
        .board_clk (board_clk),
        .reset     (reset),
        .async_in  (sync_raw),
        .sync_out  (sync_q)
    );

    assign {start_s, p1_up_s, p1_dn_s, p2_up_s, p2_dn_s} = sync_q;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    pong_state_t      state_q, state_d;
    logic [8:0]       p1_y_q, p1_y_d, p2_y_q, p2_y_d;
    logic [9:0]       ball_x_q, ball_x_d;
    logic [8:0]       ball_y_q, ball_y_d;
    logic             dx_neg_q, dx_neg_d;   // 1: ball moving left
    logic             dy_neg_q, dy_neg_d;   // 1: ball moving up
    logic [3:0]       s1_q, s1_d, s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             game_over_q;

    function automatic logic [8:0] paddle_step(input logic [8:0] y,
                                               input logic up,
                                               input logic dn);
        if (up && !dn)
            return (y < PAD_STEP) ? '0 : y - PAD_STEP;
        if (dn && !up)
            return (y > PAD_MAX - PAD_STEP) ? PAD_MAX : y + PAD_STEP;
        return y;
    endfunction

    // ---------------------------------------------------------------
    // Collision detection, all against pre-update positions
    // ---------------------------------------------------------------
    logic [10:0] bx;
    logic [9:0]  by, p1e, p2e;
    logic        ov1, ov2, miss_l, miss_r, hit1, hit2, wall_top, wall_bot;
    logic [3:0]  s1_inc, s2_inc;

    assign bx  = {1'b0, ball_x_q};
    assign by  = {1'b0, ball_y_q};
    assign p1e = {1'b0, p1_y_q};
    assign p2e = {1'b0, p2_y_q};

    assign ov1 = (by + Y_BSZ > p1e) && (by < p1e + Y_PH);
    assign ov2 = (by + Y_BSZ > p2e) && (by < p2e + Y_PH);

    assign miss_l   =  dx_neg_q && (bx <= X_SPD);
    assign miss_r   = !dx_neg_q && (bx >= X_MISS_R);
    assign hit1     =  dx_neg_q && (bx >= X_HIT1) && (bx <= X_HIT1 + X_SPD) && ov1;
    assign hit2     = !dx_neg_q && (bx <= X_HIT2) && (bx + X_SPD >= X_HIT2) && ov2;
    assign wall_top =  dy_neg_q && (by < Y_SPD);
    assign wall_bot = !dy_neg_q && (by + Y_SPD > Y_BOT);

    assign s1_inc = (s1_q < WIN) ? s1_q + 4'd1 : s1_q;
    assign s2_inc = (s2_q < WIN) ? s2_q + 4'd1 : s2_q;

    logic [10:0] nx;
    logic [9:0]  ny;

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        p1_y_d   = p1_y_q;
        p2_y_d   = p2_y_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dx_neg_d = dx_neg_q;
        dy_neg_d = dy_neg_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        cnt_d    = cnt_q;
        nx       = bx;
        ny       = by;

        if (state_q != QI && !start_s) begin
            // Switch dropped: abandon the game and restore power-up values.
            state_d  = QI;
            p1_y_d   = PAD_Y0;
            p2_y_d   = PAD_Y0;
            ball_x_d = X_SERVE[9:0];
            ball_y_d = Y_SERVE[8:0];
            dx_neg_d = 1'b0;
            dy_neg_d = 1'b0;
            s1_d     = '0;
            s2_d     = '0;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                QI: begin
                    if (start_s) begin
                        state_d = QGAME_1;
                        s1_d    = '0;
                        s2_d    = '0;
                        cnt_d   = '0;
                    end
                end

                QGAME_1: begin
                    if (frame_tick) begin
                        p1_y_d = paddle_step(p1_y_q, p1_up_s, p1_dn_s);
                        p2_y_d = paddle_step(p2_y_q, p2_up_s, p2_dn_s);
                        if (cnt_q == SERVE_LAST) begin
                            state_d = QGAME_2;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end

                QGAME_2: begin
                    if (frame_tick) begin
                        p1_y_d = paddle_step(p1_y_q, p1_up_s, p1_dn_s);
                        p2_y_d = paddle_step(p2_y_q, p2_up_s, p2_dn_s);
                        if (miss_l || miss_r) begin
                            // Miss overrides any bounce this frame; serve goes
                            // back toward the player who missed.
                            if (miss_l) begin
                                s2_d    = s2_inc;
                                state_d = (s2_inc == WIN) ? QDONE : QGAME_1;
                            end else begin
                                s1_d    = s1_inc;
                                state_d = (s1_inc == WIN) ? QDONE : QGAME_1;
                            end
                            ball_x_d = X_SERVE[9:0];
                            ball_y_d = Y_SERVE[8:0];
                            dx_neg_d = miss_l;
                            cnt_d    = '0;
                        end else begin
                            if (hit1) begin
                                nx       = X_HIT1;
                                dx_neg_d = 1'b0;
                            end else if (hit2) begin
                                nx       = X_HIT2;
                                dx_neg_d = 1'b1;
                            end else begin
                                nx = dx_neg_q ? bx - X_SPD : bx + X_SPD;
                            end

                            if (wall_top) begin
                                ny       = '0;
                                dy_neg_d = 1'b0;
                            end else if (wall_bot) begin
                                ny       = Y_BOT;
                                dy_neg_d = 1'b1;
                            end else begin
                                ny = dy_neg_q ? by - Y_SPD : by + Y_SPD;
                            end

                            ball_x_d = nx[9:0];
                            ball_y_d = ny[8:0];
                        end
                    end
                end

                QDONE: begin
                    // Everything frozen until start is released.
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q     <= QI;
            p1_y_q      <= PAD_Y0;
            p2_y_q      <= PAD_Y0;
            ball_x_q    <= X_SERVE[9:0];
            ball_y_q    <= Y_SERVE[8:0];
            dx_neg_q    <= 1'b0;
            dy_neg_q    <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            cnt_q       <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            p1_y_q      <= p1_y_d;
            p2_y_q      <= p2_y_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dx_neg_q    <= dx_neg_d;
            dy_neg_q    <= dy_neg_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            cnt_q       <= cnt_d;
            game_over_q <= (state_d == QDONE);
        end
    end

    assign p1_y      = p1_y_q;
    assign p2_y      = p2_y_q;
    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign p1_score  = s1_q;
    assign p2_score  = s2_q;
    assign state     = state_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: a table of hand-computed serve and
// rally vectors, followed by model-tracked sequences for paddle hits, misses,
// a full game to WIN_SCORE, start release and asynchronous reset.
module tb_pong_game_ctrl;

    logic       board_clk = 1'b0;
    logic       reset, frame_tick, start;
    logic       p1_up, p1_dn, p2_up, p2_dn;
    logic [8:0] p1_y, p2_y, ball_y;
    logic [9:0] ball_x;
    logic [3:0] p1_score, p2_score;
    logic [1:0] state;
    logic       game_over;

    pong_game_ctrl dut (
        .board_clk  (board_clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .p1_up      (p1_up),
        .p1_dn      (p1_dn),
        .p2_up      (p2_up),
        .p2_dn      (p2_dn),
        .p1_y       (p1_y),
        .p2_y       (p2_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .state      (state),
        .game_over  (game_over)
    );

    always #5 board_clk = ~board_clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- reference model (one call per frame / settle) ----------
    int m_state, m_p1y, m_p2y, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_cnt;
    bit m_hit1;

    task automatic model_reset_game();
        m_state = 0; m_p1y = 200; m_p2y = 200; m_bx = 316; m_by = 236;
        m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0; m_cnt = 0;
    endtask

    function automatic int pad(input int y, input bit up, input bit dn);
        if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
        if (dn && !up) return (y + 4 > 400) ? 400 : y + 4;
        return y;
    endfunction

    task automatic model_step(input bit tick, input bit st,
                              input bit u1, input bit d1, input bit u2, input bit d2);
        int np1, np2;
        m_hit1 = 0;
        if (!st && m_state != 0) begin
            model_reset_game();
            return;
        end
        np1 = pad(m_p1y, u1, d1);
        np2 = pad(m_p2y, u2, d2);
        case (m_state)
            0: if (st) begin m_state = 1; m_s1 = 0; m_s2 = 0; m_cnt = 0; end
            1: if (tick) begin
                m_p1y = np1; m_p2y = np2;
                if (m_cnt == 59) begin m_state = 2; m_cnt = 0; end
                else m_cnt++;
            end
            2: if (tick) begin
                if (m_dx < 0 && m_bx <= 2) begin
                    if (m_s2 < 10) m_s2++;
                    m_state = (m_s2 == 10) ? 3 : 1;
                    m_bx = 316; m_by = 236; m_dx = -1; m_cnt = 0;
                end else if (m_dx > 0 && m_bx >= 630) begin
                    if (m_s1 < 10) m_s1++;
                    m_state = (m_s1 == 10) ? 3 : 1;
                    m_bx = 316; m_by = 236; m_dx = 1; m_cnt = 0;
                end else begin
                    if (m_dx < 0 && m_bx >= 30 && m_bx - 2 <= 30 &&
                        m_by + 8 > m_p1y && m_by < m_p1y + 80) begin
                        m_bx = 30; m_dx = 1; m_hit1 = 1;
                    end else if (m_dx > 0 && m_bx <= 602 && m_bx + 2 >= 602 &&
                                 m_by + 8 > m_p2y && m_by < m_p2y + 80) begin
                        m_bx = 602; m_dx = -1;
                    end else begin
                        m_bx = m_bx + 2 * m_dx;
                    end
                    if (m_dy < 0 && m_by < 2) begin m_by = 0; m_dy = 1; end
                    else if (m_dy > 0 && m_by + 2 > 472) begin m_by = 472; m_dy = -1; end
                    else m_by = m_by + 2 * m_dy;
                end
                m_p1y = np1; m_p2y = np2;
            end
            default: ;
        endcase
    endtask

    task automatic compare_model(input string tag);
        check({tag, " state"}, int'(state), m_state);
        check({tag, " p1_y"}, int'(p1_y), m_p1y);
        check({tag, " p2_y"}, int'(p2_y), m_p2y);
        check({tag, " ball_x"}, int'(ball_x), m_bx);
        check({tag, " ball_y"}, int'(ball_y), m_by);
        check({tag, " p1_score"}, int'(p1_score), m_s1);
        check({tag, " p2_score"}, int'(p2_score), m_s2);
        check({tag, " game_over"}, int'(game_over), (m_state == 3) ? 1 : 0);
    endtask

    // ---------------- stimulus helpers ----------------------------------------
    // Buttons are applied two edges before the tick edge so the synchronizer
    // has delivered them when the frame is processed.
    task automatic frame(input bit u1, input bit d1, input bit u2, input bit d2);
        p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
        repeat (2) begin @(posedge board_clk); #1; end
        frame_tick = 1'b1;
        @(posedge board_clk); #1;
        frame_tick = 1'b0;
        model_step(1'b1, start, u1, d1, u2, d2);
    endtask

    task automatic settle();
        repeat (3) begin @(posedge board_clk); #1; end
        model_step(1'b0, start, p1_up, p1_dn, p2_up, p2_dn);
    endtask

    task automatic steer(input int py, input int target, output bit up, output bit dn);
        up = (py > target + 2);
        dn = (py < target - 2);
    endtask

    function automatic int track_t(input int by);
        int t = by - 36;
        if (t < 0) t = 0;
        if (t > 400) t = 400;
        return t;
    endfunction

    function automatic int away_t(input int by);
        return (by + 4 < 240) ? 400 : 0;
    endfunction

    typedef struct {
        bit u1, d1, u2, d2;
        int n;
        int p1y, p2y, bx, by, st;
    } vec_t;

    vec_t vt[11];

    initial begin
        bit u1, d1, u2, d2, seen;
        int sv_bx, sv_by, sv_s1;

        reset = 1'b1; frame_tick = 1'b0; start = 1'b0;
        p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
        model_reset_game();

        #12;
        check("reset state", int'(state), 0);
        check("reset p1_y", int'(p1_y), 200);
        check("reset p2_y", int'(p2_y), 200);
        check("reset ball_x", int'(ball_x), 316);
        check("reset ball_y", int'(ball_y), 236);
        check("reset scores", int'({p1_score, p2_score}), 0);
        check("reset game_over", int'(game_over), 0);
        @(negedge board_clk);
        reset = 1'b0;

        start = 1'b1;
        settle();
        check("start -> serve", int'(state), 1);

        // Serve countdown, paddle clamps, then first rally frames.
        vt[0]  = '{0, 1, 0, 1, 25,  300, 300, 316, 236, 1};
        vt[1]  = '{0, 1, 0, 1, 25,  400, 400, 316, 236, 1};
        vt[2]  = '{1, 1, 1, 1, 5,   400, 400, 316, 236, 1};
        vt[3]  = '{0, 1, 0, 0, 4,   400, 400, 316, 236, 1};
        vt[4]  = '{0, 1, 0, 0, 1,   400, 400, 316, 236, 2};
        vt[5]  = '{0, 1, 0, 1, 118, 400, 400, 552, 472, 2};
        vt[6]  = '{0, 0, 0, 0, 1,   400, 400, 554, 472, 2};
        vt[7]  = '{0, 0, 0, 0, 1,   400, 400, 556, 470, 2};
        vt[8]  = '{0, 0, 0, 0, 22,  400, 400, 600, 426, 2};
        vt[9]  = '{0, 0, 0, 0, 1,   400, 400, 602, 424, 2};
        vt[10] = '{0, 0, 0, 0, 1,   400, 400, 600, 422, 2};

        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < vt[i].n; k++)
                frame(vt[i].u1, vt[i].d1, vt[i].u2, vt[i].d2);
            check($sformatf("vec%0d p1_y", i), int'(p1_y), vt[i].p1y);
            check($sformatf("vec%0d p2_y", i), int'(p2_y), vt[i].p2y);
            check($sformatf("vec%0d ball_x", i), int'(ball_x), vt[i].bx);
            check($sformatf("vec%0d ball_y", i), int'(ball_y), vt[i].by);
            check($sformatf("vec%0d state", i), int'(state), vt[i].st);
            check($sformatf("vec%0d scores", i), int'({p1_score, p2_score}), 0);
        end
        compare_model("after table");

        // Both paddles track the ball until P1 returns it.
        seen = 0;
        for (int f = 0; f < 700 && !seen; f++) begin
            steer(m_p1y, track_t(m_by), u1, d1);
            steer(m_p2y, track_t(m_by), u2, d2);
            frame(u1, d1, u2, d2);
            compare_model("track");
            if (m_hit1) seen = 1;
        end
        check("p1 hit reached", int'(seen), 1);
        if (seen) begin
            check("p1 hit ball_x", int'(ball_x), 30);
            frame(1'b0, 1'b0, 1'b0, 1'b0);
            check("p1 hit rebound ball_x", int'(ball_x), 32);
        end

        // P1 dodges the ball: P2 scores and play returns to serve.
        seen = 0;
        for (int f = 0; f < 2000 && !seen; f++) begin
            steer(m_p1y, away_t(m_by), u1, d1);
            steer(m_p2y, track_t(m_by), u2, d2);
            frame(u1, d1, u2, d2);
            compare_model("p1 miss");
            if (m_s2 == 1) seen = 1;
        end
        check("p1 miss reached", int'(seen), 1);
        check("p1 miss p2_score", int'(p2_score), 1);
        check("p1 miss state", int'(state), 1);
        check("p1 miss recentre x", int'(ball_x), 316);
        check("p1 miss recentre y", int'(ball_y), 236);

        // P2 dodges every ball until P1 wins.
        seen = 0;
        for (int f = 0; f < 4500 && !seen; f++) begin
            steer(m_p1y, track_t(m_by), u1, d1);
            steer(m_p2y, away_t(m_by), u2, d2);
            frame(u1, d1, u2, d2);
            compare_model("to win");
            if (m_state == 3) seen = 1;
        end
        check("win reached", int'(seen), 1);
        check("win p1_score", int'(p1_score), 10);
        check("win p2_score", int'(p2_score), 1);
        check("win state", int'(state), 3);
        check("win game_over", int'(game_over), 1);

        // Done state is frozen even with frames and buttons.
        sv_bx = int'(ball_x); sv_by = int'(ball_y); sv_s1 = int'(p1_score);
        frame(1'b1, 1'b0, 1'b1, 1'b0);
        frame(1'b1, 1'b0, 1'b1, 1'b0);
        check("done frozen ball_x", int'(ball_x), sv_bx);
        check("done frozen ball_y", int'(ball_y), sv_by);
        check("done frozen p1_score", int'(p1_score), sv_s1);
        compare_model("done");

        start = 1'b0;
        settle();
        check("release state", int'(state), 0);
        check("release scores", int'({p1_score, p2_score}), 0);
        check("release p1_y", int'(p1_y), 200);
        check("release game_over", int'(game_over), 0);
        compare_model("release");

        // Asynchronous reset in the middle of a rally.
        start = 1'b1;
        settle();
        for (int f = 0; f < 70; f++) frame(1'b0, 1'b1, 1'b1, 1'b0);
        compare_model("pre reset");
        check("pre reset in rally", int'(state), 2);
        @(negedge board_clk);
        #2 reset = 1'b1;
        #1;
        check("async reset state", int'(state), 0);
        check("async reset p1_y", int'(p1_y), 200);
        check("async reset p2_y", int'(p2_y), 200);
        check("async reset ball_x", int'(ball_x), 316);
        check("async reset ball_y", int'(ball_y), 236);
        check("async reset scores", int'({p1_score, p2_score}), 0);
        check("async reset game_over", int'(game_over), 0);
        #20 reset = 1'b0;
        #20;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
        $fatal(1, "timeout");
    end

endmodule
